// File: rtl/vip_relu_maxpool2x2.sv
// Streaming ReLU + 2x2/stride-2 max-pool; even rows park pairwise maxima in a half-row line
// buffer, odd rows fold them in and emit one word per window. Optional ReLU: VIP_MAXPOOL_RELU_EN.
module vip_relu_maxpool2x2 #(
    parameter int DWIDTH = 32,
    parameter int IMG_W  = 112,
    parameter int IMG_H  = 112
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_rdreq,
    input  logic              in_empty,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_wrreq,
    input  logic              out_full,
    output logic              frame_done,
    output logic [0:0]        fsm_state
);

    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam logic [0:0] S_EVEN = 1'b0;
    localparam logic [0:0] S_ODD  = 1'b1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [0:0]        state;
    logic              rd_vld;
    logic [DWIDTH-1:0] h;
    logic [DWIDTH-1:0] pix_v;
    logic [DWIDTH-1:0] lb_q;
    logic [DWIDTH-1:0] max_hv;
    logic [DWIDTH-1:0] max_lbv;
    logic [LB_AW-1:0]  lb_addr;
    logic              col_last;
    logic              row_last;
    logic [DWIDTH-1:0] lb [LB_DEPTH];

    function automatic logic [DWIDTH-1:0] smax(input logic [DWIDTH-1:0] a,
                                               input logic [DWIDTH-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // Handshake: both sides are FIFO-style. A read is requested whenever upstream is non-empty
    // and downstream has room; the word arrives one cycle later (rd_vld) and is always consumed.
    // out_wrreq is a write strobe with no back-pressure; out_full's slack absorbs the one read
    // that may still be in flight when it rises.
    assign in_rdreq = reset & ~in_empty & ~out_full;

`ifdef VIP_MAXPOOL_RELU_EN
    assign pix_v = in_data[DWIDTH-1] ? '0 : in_data;
`else
    assign pix_v = in_data;
`endif

    assign lb_addr   = LB_AW'(col >> 1);
    assign lb_q      = lb[lb_addr];
    assign max_hv    = smax(h, pix_v);
    assign max_lbv   = smax(lb_q, pix_v);
    assign col_last  = (col == COL_LAST);
    assign row_last  = (row == ROW_LAST);
    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_vld     <= 1'b0;
            col        <= '0;
            row        <= '0;
            state      <= S_EVEN;
            h          <= '0;
            out_data   <= '0;
            out_wrreq  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rd_vld     <= in_rdreq;
            out_wrreq  <= 1'b0;
            frame_done <= 1'b0;
            if (rd_vld) begin
                if (state == S_EVEN) begin
                    if (!col[0]) begin
                        h <= pix_v;
                    end
                end else begin
                    if (!col[0]) begin
                        h <= max_lbv;
                    end else begin
                        out_data   <= max_hv;
                        out_wrreq  <= 1'b1;
                        frame_done <= row_last & col_last;
                    end
                end

                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row   <= '0;
                        state <= S_EVEN;
                    end else begin
                        row   <= row + 1'b1;
                        state <= ~state;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Not reset: every even row rewrites each entry before the following odd row reads it.
    always_ff @(posedge clock) begin
        if (reset && rd_vld && (state == S_EVEN) && col[0]) begin
            lb[lb_addr] <= max_hv;
        end
    end

endmodule

// File: tb/tb_vip_relu_maxpool2x2.sv
// Bench for vip_relu_maxpool2x2 at 4x4: a FIFO-like source, a window-max reference model
// feeding an expected queue, and one negedge process that checks outputs and drives stalls.
module tb_vip_relu_maxpool2x2;

    localparam int DW   = 32;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NOUT = (W / 2) * (H / 2);

    typedef logic [DW-1:0] frame_t [NPIX];
    typedef logic [DW-1:0] pool_t [NOUT];

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_empty = 1'b1;
    logic          out_full = 1'b0;
    logic          in_rdreq;
    logic [DW-1:0] out_data;
    logic          out_wrreq;
    logic          frame_done;
    logic [0:0]    fsm_state;

    vip_relu_maxpool2x2 #(.DWIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_rdreq   (in_rdreq),
        .in_empty   (in_empty),
        .out_data   (out_data),
        .out_wrreq  (out_wrreq),
        .out_full   (out_full),
        .frame_done (frame_done),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] src_q[$];
    int  checks = 0;
    int  errors = 0;
    int  fetch_cnt = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  gap_mode = 0;
    bit  rst_req = 1'b0;
    bit  force_nonempty = 1'b1;
    bit  full_force = 1'b0;
    bit  full_rand = 1'b0;
    bit  gap_tog = 1'b0;
    frame_t ramp;
    frame_t f3;
    frame_t fr;
    pool_t  res;
    pool_t  lit2;
    int  base;
    int  dbase;
    int  wbase;

    function automatic logic [DW-1:0] relu_m(input logic [DW-1:0] x);
`ifdef VIP_MAXPOOL_RELU_EN
        return ($signed(x) < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Reference: max of each 2x2 window of the rectified frame, windows in raster order.
    function automatic void pool_model(input frame_t f, output pool_t r);
        for (int wr = 0; wr < H / 2; wr++) begin
            for (int wc = 0; wc < W / 2; wc++) begin
                logic [DW-1:0] best;
                best = relu_m(f[(2 * wr) * W + 2 * wc]);
                for (int dy = 0; dy < 2; dy++) begin
                    for (int dx = 0; dx < 2; dx++) begin
                        logic [DW-1:0] v;
                        v = relu_m(f[(2 * wr + dy) * W + 2 * wc + dx]);
                        if ($signed(v) > $signed(best)) best = v;
                    end
                end
                r[wr * (W / 2) + wc] = best;
            end
        end
    endfunction

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic send_frame(input frame_t f);
        pool_t r;
        pool_model(f, r);
        for (int i = 0; i < NPIX; i++) src_q.push_back(f[i]);
        for (int i = 0; i < NOUT; i++) exp_q.push_back({(i == NOUT - 1), r[i]});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            wait_cycle();
            n++;
        end
        check("drain_timeout", (n >= 3000), 0);
        repeat (6) wait_cycle();
    endtask

    task automatic wait_fetches(input int target);
        int n;
        n = 0;
        while (fetch_cnt < target && n < 500) begin
            wait_cycle();
            n++;
        end
        check("fetch_timeout", (n >= 500), 0);
    endtask

    // upstream FIFO model: word appears one cycle after the read request
    initial begin
        forever begin
            @(posedge clock);
            if (in_rdreq === 1'b1) begin
                #1;
                if (src_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL src_underflow: got read with empty source at %0t", $time);
                end else begin
                    in_data = src_q.pop_front();
                end
                fetch_cnt++;
            end
        end
    end

    // scoreboard compare, then drive inputs for the next cycle
    initial begin
        forever begin
            @(negedge clock);
            check("rdreq_rule", in_rdreq, reset & ~in_empty & ~out_full);
            if (out_wrreq === 1'b1) begin
                wr_cnt++;
                if (frame_done === 1'b1) done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_write: got unexpected write %0h, required none", out_data);
                end else begin
                    check("out_write", {frame_done, out_data}, exp_q.pop_front());
                end
            end else begin
                check("frame_done_idle", frame_done, 0);
            end
            reset   = rst_req;
            gap_tog = ~gap_tog;
            in_empty = force_nonempty ? 1'b0 :
                       ((src_q.size() == 0) ||
                        (gap_mode == 1 && gap_tog) ||
                        (gap_mode == 2 && $urandom_range(0, 2) == 0));
            out_full = full_force || (full_rand && $urandom_range(0, 4) == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NPIX; i++) ramp[i] = DW'(i + 1);
        lit2 = '{32'd6, 32'd8, 32'd14, 32'd16};

        // reset held with a non-empty upstream
        repeat (3) wait_cycle();
        check("rst_rdreq", in_rdreq, 0);
        check("rst_wrreq", out_wrreq, 0);
        check("rst_done", frame_done, 0);
        check("rst_data", out_data, 0);
        force_nonempty = 1'b0;
        rst_req = 1'b1;
        repeat (2) wait_cycle();

        // ramp frame, no stalls
        pool_model(ramp, res);
        for (int k = 0; k < NOUT; k++) check("model_ramp", res[k], lit2[k]);
        wbase = wr_cnt;
        dbase = done_cnt;
        send_frame(ramp);
        wait_drain();
        check("ramp_writes", wr_cnt - wbase, 4);
        check("ramp_done", done_cnt - dbase, 1);

        // negative top-left window
        for (int i = 0; i < NPIX; i++) f3[i] = DW'(1);
        f3[0] = -32'sd5;
        f3[1] = -32'sd3;
        f3[4] = -32'sd7;
        f3[5] = -32'sd9;
        pool_model(f3, res);
`ifdef VIP_MAXPOOL_RELU_EN
        check("model_neg", res[0], 0);
`else
        check("model_neg", res[0], 33'h0_FFFF_FFFD);
`endif
        send_frame(f3);
        wait_drain();

        // downstream full for 10 cycles after pixel 7
        base = fetch_cnt;
        wbase = wr_cnt;
        send_frame(ramp);
        wait_fetches(base + 7);
        full_force = 1'b1;
        repeat (10) wait_cycle();
        check("full_no_reads", fetch_cnt - base, 7);
        full_force = 1'b0;
        wait_drain();
        check("full_writes", wr_cnt - wbase, 4);

        // toggling empty, then two frames back-to-back
        gap_mode = 1;
        send_frame(ramp);
        wait_drain();
        gap_mode = 0;
        dbase = done_cnt;
        wbase = wr_cnt;
        send_frame(ramp);
        send_frame(ramp);
        wait_drain();
        check("b2b_writes", wr_cnt - wbase, 8);
        check("b2b_done", done_cnt - dbase, 2);

        // reset after 6 pixels of an aborted frame
        base = fetch_cnt;
        for (int i = 0; i < 6; i++) src_q.push_back(ramp[i]);
        wait_fetches(base + 6);
        rst_req = 1'b0;
        wait_cycle();
        src_q.delete();
        repeat (2) wait_cycle();
        rst_req = 1'b1;
        wait_cycle();
        wbase = wr_cnt;
        send_frame(ramp);
        wait_drain();
        check("abort_writes", wr_cnt - wbase, 4);

        // randomized frames with random stalls on both sides
        gap_mode = 2;
        full_rand = 1'b1;
        for (int it = 0; it < 12; it++) begin
            int nf;
            nf = $urandom_range(1, 3);
            for (int k = 0; k < nf; k++) begin
                for (int i = 0; i < NPIX; i++) begin
                    if ($urandom_range(0, 1) == 1) fr[i] = $urandom();
                    else fr[i] = DW'(int'($urandom_range(0, 40)) - 20);
                end
                send_frame(fr);
            end
            wait_drain();
        end
        gap_mode = 0;
        full_rand = 1'b0;
        repeat (4) wait_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
